// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter segment sequencer.
package counter_seq_pkg;

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  localparam int unsigned INCR_W_DEF = 32;
  localparam int unsigned DUR_W_DEF  = 32;
  localparam int unsigned WRAP_W     = 16;

endpackage

// File: rtl/counter_seq_table.sv
// Segment table: NUM_SEG (increment, duration) entries, one sync write port, one async read port.
module counter_seq_table
  import counter_seq_pkg::*;
#(
  parameter int unsigned NUM_SEG = 4,
  parameter int unsigned INCR_W  = INCR_W_DEF,
  parameter int unsigned DUR_W   = DUR_W_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       we,
  input  logic [$clog2(NUM_SEG)-1:0] wr_addr,
  input  logic [INCR_W-1:0]          wr_incr,
  input  logic [DUR_W-1:0]           wr_dur,
  input  logic [$clog2(NUM_SEG)-1:0] rd_addr,
  output logic [INCR_W-1:0]          rd_incr,
  output logic [DUR_W-1:0]           rd_dur
);

  logic [INCR_W-1:0] incr_mem [NUM_SEG];
  logic [DUR_W-1:0]  dur_mem  [NUM_SEG];
  logic              wr_ok;
  logic              rd_ok;

  // Index range guards only matter when NUM_SEG is not a power of two.
  assign wr_ok = we && (int'(wr_addr) < int'(NUM_SEG));
  assign rd_ok = int'(rd_addr) < int'(NUM_SEG);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_SEG); i++) begin
        incr_mem[i] <= '0;
        dur_mem[i]  <= '0;
      end
    end else if (wr_ok) begin
      incr_mem[wr_addr] <= wr_incr;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  assign rd_incr = rd_ok ? incr_mem[rd_addr] : '0;
  assign rd_dur  = rd_ok ? dur_mem[rd_addr]  : '0;

endmodule

// File: rtl/counter_seq.sv
// Segment sequencer: owns the counter's resetn/incr_i and steps incr through a programmed table.
// Define COUNTER_SEQ_LOOP_EN to add loop_i / wrap_cnt_o for continuous passes over the table.
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int unsigned NUM_SEG = 4,
  parameter int unsigned INCR_W  = INCR_W_DEF,
  parameter int unsigned DUR_W   = DUR_W_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cfg_we_i,
  input  logic [$clog2(NUM_SEG)-1:0] cfg_addr_i,
  input  logic [INCR_W-1:0]          cfg_incr_i,
  input  logic [DUR_W-1:0]           cfg_dur_i,
  input  logic [$clog2(NUM_SEG):0]   num_seg_i,
  input  logic                       start_i,
  input  logic                       stop_i,
`ifdef COUNTER_SEQ_LOOP_EN
  input  logic                       loop_i,
  output logic [WRAP_W-1:0]          wrap_cnt_o,
`endif
  output logic                       counter_resetn_o,
  output logic [INCR_W-1:0]          incr_o,
  output logic [$clog2(NUM_SEG)-1:0] seg_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned AddrW = $clog2(NUM_SEG);
  localparam int unsigned CntW  = AddrW + 1;

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DUR_W-1:0]   timer_q, timer_d;
  logic [AddrW-1:0]   seg_idx_q, seg_idx_d;
  logic [INCR_W-1:0]  incr_q, incr_d;
  logic               cres_q, cres_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef COUNTER_SEQ_LOOP_EN
  logic [WRAP_W-1:0]  wrap_q, wrap_d;
`endif

  logic               start_ok, last_seg, seg_end, loop_now, table_we;
  logic [AddrW-1:0]   nxt_idx, rd_addr;
  logic [INCR_W-1:0]  rd_incr;
  logic [DUR_W-1:0]   rd_dur, rd_len;

`ifdef COUNTER_SEQ_LOOP_EN
  assign loop_now = loop_i;
`else
  assign loop_now = 1'b0;
`endif

  assign start_ok = start_i && (num_seg_i != '0) && (num_seg_i <= CntW'(NUM_SEG));
  assign last_seg = ({1'b0, seg_idx_q} == cnt_q - CntW'(1));
  assign seg_end  = (timer_q == DUR_W'(1));
  assign nxt_idx  = last_seg ? '0 : seg_idx_q + AddrW'(1);
  // ARM preloads entry 0; RUN looks ahead to the entry that follows the current one.
  assign rd_addr  = (state_q == StArm) ? '0 : nxt_idx;
  assign rd_len   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
  assign table_we = cfg_we_i && !busy_q;

  counter_seq_table #(
    .NUM_SEG (NUM_SEG),
    .INCR_W  (INCR_W),
    .DUR_W   (DUR_W)
  ) u_table (
    .clk     (clk),
    .resetn  (resetn),
    .we      (table_we),
    .wr_addr (cfg_addr_i),
    .wr_incr (cfg_incr_i),
    .wr_dur  (cfg_dur_i),
    .rd_addr (rd_addr),
    .rd_incr (rd_incr),
    .rd_dur  (rd_dur)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (start_q) state_d = StArm;
        StArm:          state_d = StRun;
        StRun:          if (seg_end && last_seg && !loop_now) state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    start_d   = 1'b0;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    seg_idx_d = seg_idx_q;
    incr_d    = incr_q;
    cres_d    = cres_q;
`ifdef COUNTER_SEQ_LOOP_EN
    wrap_d    = wrap_q;
`endif
    // A valid start is captured for one cycle before ARM, giving the start-to-release latency.
    if (!stop_i && !start_q && start_ok && (state_q == StIdle || state_q == StDone)) begin
      start_d = 1'b1;
      cnt_d   = num_seg_i;
    end
    unique case (state_d)
      StIdle, StArm: begin
        cres_d    = 1'b0;
        incr_d    = '0;
        seg_idx_d = '0;
        timer_d   = '0;
`ifdef COUNTER_SEQ_LOOP_EN
        if (state_d == StArm) wrap_d = '0;
`endif
      end
      StRun: begin
        cres_d = 1'b1;
        if (state_q == StArm || seg_end) begin
          seg_idx_d = rd_addr;
          incr_d    = rd_incr;
          timer_d   = rd_len;
`ifdef COUNTER_SEQ_LOOP_EN
          if (state_q == StRun && last_seg) wrap_d = wrap_q + WRAP_W'(1);
`endif
        end else begin
          timer_d = timer_q - DUR_W'(1);
        end
      end
      StDone: begin
        cres_d  = 1'b1;
        incr_d  = '0;
        timer_d = '0;
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d == StArm) || (state_d == StRun);
  assign done_d = (state_d == StDone);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q   <= 1'b0;
      cnt_q     <= '0;
      timer_q   <= '0;
      seg_idx_q <= '0;
      incr_q    <= '0;
      cres_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef COUNTER_SEQ_LOOP_EN
      wrap_q    <= '0;
`endif
    end else begin
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      seg_idx_q <= seg_idx_d;
      incr_q    <= incr_d;
      cres_q    <= cres_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef COUNTER_SEQ_LOOP_EN
      wrap_q    <= wrap_d;
`endif
    end
  end

  assign counter_resetn_o = cres_q;
  assign incr_o           = incr_q;
  assign seg_idx_o        = seg_idx_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
`ifdef COUNTER_SEQ_LOOP_EN
  assign wrap_cnt_o       = wrap_q;
`endif

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: schedule-based output model, attached counter model, directed tests.
module tb_counter_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_addr_i = '0;
  logic [31:0] cfg_incr_i = '0;
  logic [31:0] cfg_dur_i = '0;
  logic [2:0]  num_seg_i = '0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        counter_resetn_o;
  logic [31:0] incr_o;
  logic [1:0]  seg_idx_o;
  logic        busy_o;
  logic        done_o;
`ifdef COUNTER_SEQ_LOOP_EN
  logic        loop_i = 1'b0;
  logic [15:0] wrap_cnt_o;
`endif

  always #5 clk = ~clk;

  counter_seq #(
    .NUM_SEG (4),
    .INCR_W  (32),
    .DUR_W   (32)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cfg_we_i         (cfg_we_i),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_incr_i       (cfg_incr_i),
    .cfg_dur_i        (cfg_dur_i),
    .num_seg_i        (num_seg_i),
    .start_i          (start_i),
    .stop_i           (stop_i),
`ifdef COUNTER_SEQ_LOOP_EN
    .loop_i           (loop_i),
    .wrap_cnt_o       (wrap_cnt_o),
`endif
    .counter_resetn_o (counter_resetn_o),
    .incr_o           (incr_o),
    .seg_idx_o        (seg_idx_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  // Attached counter: async clear on low resetn, adds incr_i every edge otherwise.
  logic [31:0] ctr;
  always @(posedge clk or negedge counter_resetn_o) begin
    if (!counter_resetn_o) ctr <= '0;
    else ctr <= ctr + incr_o;
  end

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs as a per-cycle schedule built from the table at ARM time.
  typedef struct packed {
    logic        cres;
    logic [31:0] incr;
    logic [1:0]  seg;
    logic        busy;
    logic        done;
  } out_t;

  out_t        cur = '0;
  out_t        q[$];
  logic        pending = 1'b0;
  logic        m_run = 1'b0;
  int          m_cnt = 0;
  int unsigned m_wrap = 0;
  logic [31:0] m_incr [4];
  logic [31:0] m_dur  [4];

  task automatic build_pass();
    for (int k = 0; k < m_cnt; k++) begin
      int unsigned len;
      len = (m_dur[k] == 0) ? 1 : m_dur[k];
      for (int unsigned r = 0; r < len; r++)
        q.push_back('{cres: 1'b1, incr: m_incr[k], seg: 2'(k), busy: 1'b1, done: 1'b0});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        cur = '0; q.delete(); pending = 1'b0; m_run = 1'b0; m_cnt = 0; m_wrap = 0;
        for (int i = 0; i < 4; i++) begin m_incr[i] = '0; m_dur[i] = '0; end
      end else begin
        if (cfg_we_i && !cur.busy) begin
          m_incr[cfg_addr_i] = cfg_incr_i;
          m_dur[cfg_addr_i]  = cfg_dur_i;
        end
        if (stop_i) begin
          cur = '0; q.delete(); pending = 1'b0; m_run = 1'b0;
        end else if (pending) begin
          pending = 1'b0;
          cur = '{cres: 1'b0, incr: '0, seg: '0, busy: 1'b1, done: 1'b0};
          q.delete();
          build_pass();
          m_run = 1'b1;
          m_wrap = 0;
        end else if (m_run) begin
          if (q.size() > 0) begin
            cur = q.pop_front();
`ifdef COUNTER_SEQ_LOOP_EN
          end else if (loop_i) begin
            build_pass();
            cur = q.pop_front();
            m_wrap = (m_wrap + 1) % 65536;
`endif
          end else begin
            cur = '{cres: 1'b1, incr: '0, seg: 2'(m_cnt - 1), busy: 1'b0, done: 1'b1};
            m_run = 1'b0;
          end
        end else if (start_i && num_seg_i >= 1 && num_seg_i <= 4) begin
          pending = 1'b1;
          m_cnt = int'(num_seg_i);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cycle_outs", {counter_resetn_o, incr_o, seg_idx_o, busy_o, done_o}, cur);
`ifdef COUNTER_SEQ_LOOP_EN
        check("cycle_wrap", wrap_cnt_o, m_wrap);
`endif
      end
    end
  end

  task automatic write_entry(input logic [1:0] a, input logic [31:0] inc, input logic [31:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_incr_i = inc; cfg_dur_i = d;
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic start_pulse(input logic [2:0] n);
    start_i = 1'b1; num_seg_i = n;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (done_o !== 1'b1 && k < max) begin @(negedge clk); k++; end
    check("done_reached", done_o, 1);
  endtask

  task automatic count_incr(input string name, input logic [31:0] v, input int exp);
    int c = 0;
    while (incr_o === v && c < 40) begin c++; @(negedge clk); end
    check(name, c, exp);
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1 chk_en = 1'b1;
    check("reset_outs", {counter_resetn_o, incr_o, seg_idx_o, busy_o, done_o}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Two segments: 2 for 5 cycles then 4 for 5 cycles, counter ends at 30.
    write_entry(2'd0, 32'd2, 32'd5);
    write_entry(2'd1, 32'd4, 32'd5);
    start_pulse(3'd2);
    check("lat_n1_cres", counter_resetn_o, 0);
    check("lat_n1_busy", busy_o, 0);
    @(negedge clk);
    check("arm_busy", busy_o, 1);
    check("arm_cres", counter_resetn_o, 0);
    @(negedge clk);
    check("run_cres", counter_resetn_o, 1);
    count_incr("seg0_len", 32'd2, 5);
    count_incr("seg1_len", 32'd4, 5);
    check("done_first", done_o, 1);
    check("ctr_30", ctr, 30);

    // Restart from DONE; a write during busy must be ignored.
    start_pulse(3'd2);
    @(negedge clk);
    check("arm_ctr_clear", ctr, 0);
    write_entry(2'd0, 32'd9, 32'd5);
    check("restart_incr", incr_o, 2);
    wait_done(40);
    check("ctr_30_again", ctr, 30);

    // Stop together with start in the 3rd cycle of segment 1.
    start_pulse(3'd2);
    begin
      int k = 0;
      while (!(seg_idx_o === 2'd1 && busy_o === 1'b1) && k < 40) begin @(negedge clk); k++; end
      check("seg1_reached", seg_idx_o, 1);
    end
    repeat (2) @(negedge clk);
    stop_i = 1'b1; start_i = 1'b1; num_seg_i = 3'd2;
    @(negedge clk);
    stop_i = 1'b0; start_i = 1'b0;
    check("stop_outs", {counter_resetn_o, incr_o, busy_o, done_o}, 0);
    repeat (3) @(negedge clk);
    check("stop_stays_idle", busy_o, 0);

    // Duration 0 is one cycle.
    write_entry(2'd0, 32'd7, 32'd0);
    start_pulse(3'd1);
    @(negedge clk);
    @(negedge clk);
    check("dur0_incr", incr_o, 7);
    @(negedge clk);
    check("dur0_done", done_o, 1);
    check("ctr_7", ctr, 7);

    // Invalid counts are ignored.
    start_pulse(3'd0);
    repeat (3) @(negedge clk);
    check("num0_busy", busy_o, 0);
    start_pulse(3'd5);
    repeat (3) @(negedge clk);
    check("num5_busy", busy_o, 0);

    // Reset mid-run clears outputs at once and empties the table.
    write_entry(2'd0, 32'd3, 32'd10);
    start_pulse(3'd1);
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("async_rst_outs", {counter_resetn_o, incr_o, seg_idx_o, busy_o, done_o}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_pulse(3'd1);
    repeat (2) @(negedge clk);
    check("tbl_clr_cres", counter_resetn_o, 1);
    check("tbl_clr_incr", incr_o, 0);
    wait_done(10);
    check("tbl_clr_ctr", ctr, 0);

`ifdef COUNTER_SEQ_LOOP_EN
    // Looping over a single (1,3) segment without clearing the counter.
    write_entry(2'd0, 32'd1, 32'd3);
    loop_i = 1'b1;
    start_pulse(3'd1);
    @(negedge clk);
    @(negedge clk);
    repeat (8) @(negedge clk);
    check("loop_wrap2", wrap_cnt_o, 2);
    check("loop_ctr8", ctr, 8);
    @(negedge clk);
    check("loop_ctr9", ctr, 9);
    loop_i = 1'b0;
    wait_done(20);
    check("loop_ctr12", ctr, 12);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
